countdown_100: RTL and testbench



---
 rtl/countdown_100.sv | 175 +++++++++++++++++
 tb/tb_countdown_100.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_100.sv
// countdown_100 - loadable down-counter / interval timer, programmed value .. 0
//
// Counts from the reload register (0..MAX) down to 0, then pulses o_done.
// With i_auto_reload high it reloads and keeps running (periodic event),
// otherwise it parks in DONE with o_cnt = 0 until started or cleared.
//
// Ports
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset
//   i_load         capture min(i_load_val, MAX) into the reload register
//   i_load_val     reload value
//   i_start        (re)start countdown from the reload register
//   i_pause        level, holds the count while in RUN
//   i_clear        abort to IDLE, no done pulse
//   i_auto_reload  level, on reaching 0 reload and continue
//   o_cnt          current count (registered)
//   o_busy         high while in RUN (registered)
//   o_done         one-cycle pulse per completed countdown (registered)
//   o_bcd_tens/o_bcd_ones  decimal digits of o_cnt (only with COUNTDOWN_BCD_EN)
//
// Optional feature macro: COUNTDOWN_BCD_EN adds the registered BCD digit outputs.
//
// state | meaning
// IDLE  | not counting, o_cnt = 0
// RUN   | counting down (or paused)
// DONE  | countdown finished, o_cnt held at 0

module countdown_100 #(
  parameter int MAX   = 99,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_clear,
  input  logic             i_auto_reload,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_done
`ifdef COUNTDOWN_BCD_EN
  ,
  output logic [3:0]       o_bcd_tens,
  output logic [3:0]       o_bcd_ones
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] reload, reload_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      reload <= MAX_VAL;
      o_cnt  <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      reload <= reload_nxt;
      o_cnt  <= cnt_nxt;
      o_busy <= busy_nxt;
      o_done <= done_nxt;
    end
  end

  // Load is independent of the count path: a load together with a start
  // still lands in the reload register, while the start uses the old value.
  always_comb begin
    state_nxt  = state;
    reload_nxt = reload;
    cnt_nxt    = o_cnt;
    done_nxt   = 1'b0;

    if (i_load)
      reload_nxt = (i_load_val > MAX_VAL) ? MAX_VAL : i_load_val;

    if (i_clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (i_start) begin
      state_nxt = RUN;
      cnt_nxt   = reload;
    end else if (state == RUN && !i_pause) begin
      if (o_cnt != '0) begin
        cnt_nxt = o_cnt - CNT_W'(1);
      end else begin
        done_nxt = 1'b1;
        if (i_auto_reload)
          cnt_nxt = reload;
        else
          state_nxt = DONE;
      end
    end

    busy_nxt = (state_nxt == RUN);
  end

`ifdef COUNTDOWN_BCD_EN
  // Digits are kept as a cascaded BCD down-counter next to the binary one;
  // the reload register's digits are converted once at load time so a start
  // or reload only copies them.
  logic [7:0] reload_bcd, reload_bcd_nxt;
  logic [3:0] tens_nxt, ones_nxt;

  function automatic logic [7:0] to_bcd(input logic [CNT_W-1:0] v);
    logic [3:0]       t;
    logic [CNT_W-1:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= CNT_W'(10)) begin
        r = r - CNT_W'(10);
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reload_bcd <= to_bcd(MAX_VAL);
      o_bcd_tens <= 4'd0;
      o_bcd_ones <= 4'd0;
    end else begin
      reload_bcd <= reload_bcd_nxt;
      o_bcd_tens <= tens_nxt;
      o_bcd_ones <= ones_nxt;
    end
  end

  always_comb begin
    reload_bcd_nxt = reload_bcd;
    tens_nxt       = o_bcd_tens;
    ones_nxt       = o_bcd_ones;

    if (i_load)
      reload_bcd_nxt = to_bcd(reload_nxt);

    if (i_clear) begin
      tens_nxt = 4'd0;
      ones_nxt = 4'd0;
    end else if (i_start) begin
      tens_nxt = reload_bcd[7:4];
      ones_nxt = reload_bcd[3:0];
    end else if (state == RUN && !i_pause) begin
      if (o_cnt != '0) begin
        if (o_bcd_ones == 4'd0) begin
          ones_nxt = 4'd9;
          tens_nxt = o_bcd_tens - 4'd1;
        end else begin
          ones_nxt = o_bcd_ones - 4'd1;
        end
      end else if (i_auto_reload) begin
        tens_nxt = reload_bcd[7:4];
        ones_nxt = reload_bcd[3:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_countdown_100.sv
// Testbench for countdown_100: table of directed vectors plus hand-written
// sequences for reset, mid-run reset and the 250-cycle auto-reload run.
// Optional feature macro: COUNTDOWN_BCD_EN (checks BCD digits against o_cnt).

module tb_countdown_100;

  localparam int CNT_W = 7;

  logic             clk;
  logic             reset_n;
  logic             i_load;
  logic [CNT_W-1:0] i_load_val;
  logic             i_start;
  logic             i_pause;
  logic             i_clear;
  logic             i_auto_reload;
  logic [CNT_W-1:0] o_cnt;
  logic             o_busy;
  logic             o_done;
`ifdef COUNTDOWN_BCD_EN
  logic [3:0]       o_bcd_tens;
  logic [3:0]       o_bcd_ones;
`endif

  int checks   = 0;
  int failures = 0;

  countdown_100 #(.MAX(99), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (i_load),
    .i_load_val   (i_load_val),
    .i_start      (i_start),
    .i_pause      (i_pause),
    .i_clear      (i_clear),
    .i_auto_reload(i_auto_reload),
    .o_cnt        (o_cnt),
    .o_busy       (o_busy),
    .o_done       (o_done)
`ifdef COUNTDOWN_BCD_EN
    ,
    .o_bcd_tens   (o_bcd_tens),
    .o_bcd_ones   (o_bcd_ones)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [6:0] lv;
    logic       st;
    logic       ps;
    logic       cl;
    logic       ar;
    logic [6:0] cnt;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input int lv, input logic st, input logic ps,
                     input logic cl, input logic ar, input int cnt, input logic busy,
                     input logic done);
    vec_t v;
    v.ld = ld; v.lv = 7'(lv); v.st = st; v.ps = ps; v.cl = cl; v.ar = ar;
    v.cnt = 7'(cnt); v.busy = busy; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bcd(input string name);
`ifdef COUNTDOWN_BCD_EN
    check({name, "_bcd"}, int'(o_bcd_tens) * 10 + int'(o_bcd_ones), int'(o_cnt));
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic drive(input logic ld, input logic [6:0] lv, input logic st,
                       input logic ps, input logic cl, input logic ar);
    i_load = ld; i_load_val = lv; i_start = st;
    i_pause = ps; i_clear = cl; i_auto_reload = ar;
  endtask

  // Advance one active edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int expc;
    int last_done;
    int n_done;
    string nm;

    drive(0, 7'd0, 0, 0, 0, 0);
    reset_n = 1'b0;

    // Vector table: inputs applied before an edge, outputs expected after it.
    add(1,   5, 0, 0, 0, 0,  0, 0, 0);
    add(0,   0, 1, 0, 0, 0,  5, 1, 0);
    add(0,   0, 0, 0, 0, 0,  4, 1, 0);
    add(0,   0, 0, 0, 0, 0,  3, 1, 0);
    add(0,   0, 0, 0, 0, 0,  2, 1, 0);
    add(0,   0, 0, 0, 0, 0,  1, 1, 0);
    add(0,   0, 0, 0, 0, 0,  0, 1, 0);
    add(0,   0, 0, 0, 0, 0,  0, 0, 1);
    add(0,   0, 0, 0, 0, 0,  0, 0, 0);
    add(1, 120, 0, 0, 0, 0,  0, 0, 0);
    add(0,   0, 1, 0, 0, 0, 99, 1, 0);
    add(1,   0, 1, 0, 0, 0, 99, 1, 0);
    add(0,   0, 0, 0, 0, 0, 98, 1, 0);
    add(0,   0, 1, 0, 0, 0,  0, 1, 0);
    add(0,   0, 0, 0, 0, 0,  0, 0, 1);
    add(0,   0, 0, 0, 0, 0,  0, 0, 0);
    add(1,   3, 0, 0, 0, 0,  0, 0, 0);
    add(0,   0, 1, 0, 0, 0,  3, 1, 0);
    add(0,   0, 0, 0, 0, 0,  2, 1, 0);
    add(0,   0, 1, 0, 0, 0,  3, 1, 0);
    add(0,   0, 0, 0, 0, 0,  2, 1, 0);
    add(0,   0, 0, 0, 0, 0,  1, 1, 0);
    add(0,   0, 1, 0, 1, 0,  0, 0, 0);
    add(0,   0, 0, 0, 0, 0,  0, 0, 0);
    add(0,   0, 0, 1, 0, 0,  0, 0, 0);
    add(1,  10, 0, 0, 0, 0,  0, 0, 0);
    add(0,   0, 1, 0, 0, 0, 10, 1, 0);
    add(0,   0, 0, 0, 0, 0,  9, 1, 0);
    add(0,   0, 0, 0, 0, 0,  8, 1, 0);
    add(0,   0, 0, 0, 0, 0,  7, 1, 0);
    add(0,   0, 0, 0, 0, 0,  6, 1, 0);
    add(0,   0, 0, 1, 0, 0,  6, 1, 0);
    add(0,   0, 0, 1, 0, 0,  6, 1, 0);
    add(0,   0, 0, 1, 0, 0,  6, 1, 0);
    add(0,   0, 0, 0, 0, 0,  5, 1, 0);
    add(0,   0, 0, 0, 0, 0,  4, 1, 0);
    add(0,   0, 0, 0, 0, 0,  3, 1, 0);
    add(0,   0, 0, 0, 0, 0,  2, 1, 0);
    add(0,   0, 0, 0, 0, 0,  1, 1, 0);
    add(0,   0, 0, 0, 0, 0,  0, 1, 0);
    add(0,   0, 0, 1, 0, 0,  0, 1, 0);
    add(0,   0, 0, 0, 0, 0,  0, 0, 1);
    add(0,   0, 0, 0, 0, 0,  0, 0, 0);
    add(0,   0, 1, 0, 0, 1, 10, 1, 0);
    add(0,   0, 0, 0, 1, 1,  0, 0, 0);

    // Reset state.
    tick();
    tick();
    check("reset_cnt", int'(o_cnt), 0);
    check("reset_busy", int'(o_busy), 0);
    check("reset_done", int'(o_done), 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ps, vecs[i].cl, vecs[i].ar);
      tick();
      idx = i;
      nm = $sformatf("vec%0d", idx);
      check({nm, "_cnt"},  int'(o_cnt),  int'(vecs[i].cnt));
      check({nm, "_busy"}, int'(o_busy), int'(vecs[i].busy));
      check({nm, "_done"}, int'(o_done), int'(vecs[i].done));
      check_bcd(nm);
    end

    // Mid-run reset, asserted together with start: reset wins.
    drive(0, 7'd0, 1, 0, 0, 0);
    tick();
    drive(0, 7'd0, 0, 0, 0, 0);
    tick();
    tick();
    check("midrun_cnt_pre", int'(o_cnt), 8);
    reset_n = 1'b0;
    drive(0, 7'd0, 1, 0, 0, 0);
    tick();
    check("midrun_rst_cnt", int'(o_cnt), 0);
    check("midrun_rst_busy", int'(o_busy), 0);
    check("midrun_rst_done", int'(o_done), 0);
    reset_n = 1'b1;

    // Reload register back at MAX after reset; auto-reload for 250 cycles.
    drive(0, 7'd0, 1, 0, 0, 1);
    tick();
    check("auto_start_cnt", int'(o_cnt), 99);
    check("auto_start_busy", int'(o_busy), 1);
    drive(0, 7'd0, 0, 0, 0, 1);
    expc = 99;
    last_done = 0;
    n_done = 0;
    for (int c = 1; c <= 250; c++) begin
      logic exp_done;
      tick();
      exp_done = (expc == 0);
      expc = (expc == 0) ? 99 : expc - 1;
      nm = $sformatf("auto_c%0d", c);
      check({nm, "_cnt"}, int'(o_cnt), expc);
      check({nm, "_done"}, int'(o_done), int'(exp_done));
      check({nm, "_busy"}, int'(o_busy), 1);
      check_bcd(nm);
      if (o_done) begin
        n_done++;
        check({nm, "_spacing"}, c - last_done, 100);
        last_done = c;
      end
    end
    check("auto_done_count", n_done, 2);

    drive(0, 7'd0, 0, 0, 1, 0);
    tick();
    check("final_clear_cnt", int'(o_cnt), 0);
    check("final_clear_busy", int'(o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
